// File: rtl/operand_fetch_stage_pkg.sv
// Shared decode definitions for the operand fetch stage.
// Holds class codes, field positions and the ID/EX bundle.
package operand_fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam int REG_W = 4;
  localparam int NREG = 16;
  localparam logic [31:0] PC_OFF = 32'd8;

  localparam int F_CLS = 26;
  localparam int F_I = 25;
  localparam int F_OP = 21;
  localparam int F_L = 20;
  localparam int F_RN = 16;
  localparam int F_RD = 12;
  localparam int F_RM = 0;

  typedef enum logic [1:0] {
    CLS_DP = 2'b00,
    CLS_LS = 2'b01,
    CLS_BR = 2'b10,
    CLS_XX = 2'b11
  } cls_e;

  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_MVN = 4'hF;

  typedef struct packed {
    logic             rs1_use;
    logic [REG_W-1:0] rs1;
    logic             rs2_use;
    logic [REG_W-1:0] rs2;
    logic             rd_we;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic             use_imm;
    logic             is_load;
    logic             is_store;
    logic [3:0]       alu_op;
  } dec_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [31:0]      imm;
    logic [REG_W-1:0] rd;
    logic             rd_we;
    logic [3:0]       alu_op;
    logic             use_imm;
    logic             is_load;
    logic             is_store;
  } id_ex_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    cls_e cls;
    logic [3:0] op;
    d = '0;
    cls = cls_e'(ir[F_CLS +: 2]);
    op = ir[F_OP +: 4];
    d.alu_op = op;
    d.rs1 = ir[F_RN +: REG_W];
    d.rs2 = ir[F_RM +: REG_W];
    d.rd = ir[F_RD +: REG_W];
    unique case (1'b1)
      cls == CLS_DP: begin
        d.rs1_use = !(op == OP_MOV || op == OP_MVN);
        d.use_imm = ir[F_I];
        d.rs2_use = !ir[F_I];
        if (ir[F_I])
          d.imm = {24'b0, ir[7:0]};
        d.rd_we = op[3:2] != 2'b10;
      end
      cls == CLS_LS: begin
        d.rs1_use = 1'b1;
        d.use_imm = 1'b1;
        d.imm = {20'b0, ir[11:0]};
        d.is_load = ir[F_L];
        d.is_store = !ir[F_L];
        d.rd_we = ir[F_L];
        d.rs2_use = !ir[F_L];
        d.rs2 = ir[F_RD +: REG_W];
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register.
// Read ports and busy report the state after this cycle's clears.
module reg_scoreboard #(
  parameter int N = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          wb_clr_en,
  input  logic [AW-1:0] wb_clr_addr,
  input  logic          cancel_en,
  input  logic [AW-1:0] cancel_addr,
  input  logic          flush_en,
  input  logic [AW-1:0] flush_addr,
  input  logic [AW-1:0] rd_a_addr,
  input  logic [AW-1:0] rd_b_addr,
  output logic          rd_a_busy,
  output logic          rd_b_busy,
  output logic [N-1:0]  busy
);

  logic [N-1:0] busy_q;
  logic [N-1:0] clr_mask;
  logic [N-1:0] set_mask;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb_clr_en)
      clr_mask[wb_clr_addr] = 1'b1;
    if (cancel_en)
      clr_mask[cancel_addr] = 1'b1;
    if (flush_en)
      clr_mask[flush_addr] = 1'b1;
    if (set_en)
      set_mask[set_addr] = 1'b1;
  end

  assign busy = busy_q & ~clr_mask;
  assign rd_a_busy = busy[rd_a_addr];
  assign rd_b_busy = busy[rd_b_addr];

  // R0 is hardwired, so its bit can never become busy
  always_ff @(posedge clk) begin
    if (reset)
      busy_q <= '0;
    else
      busy_q <= (busy | set_mask) & {{(N-1){1'b1}}, 1'b0};
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode / operand fetch stage feeding EX.
// Bypasses write-back, stalls on busy registers.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_W,
  parameter logic [31:0] PC_OFFSET = PC_OFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  output logic [ADDR_W-1:0] rf_rd1_addr,
  output logic [ADDR_W-1:0] rf_rd2_addr,
  input  logic [DATA_W-1:0] rf_rd1_data,
  input  logic [DATA_W-1:0] rf_rd2_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sb_cancel_en,
  input  logic [ADDR_W-1:0] sb_cancel_addr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [31:0]       out_imm,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_we,
  output logic [3:0]        out_alu_op,
  output logic              out_use_imm,
  output logic              out_is_load,
  output logic              out_is_store
);

  dec_t dec;
  id_ex_t slot_q;
  id_ex_t slot_d;
  logic valid_q;
  logic busy1;
  logic busy2;
  logic hazard;
  logic accept;
  logic flush_clr;
  logic [NREG-1:0] busy_eff;
  logic [31:0] pc_rel;

  assign dec = decode(in_instr);
  assign rf_rd1_addr = dec.rs1;
  assign rf_rd2_addr = dec.rs2;
  assign pc_rel = in_pc + PC_OFFSET;

  // register_file returns the old value on a same-cycle write
  function automatic logic [DATA_W-1:0] fetch(
    input logic              used,
    input logic [ADDR_W-1:0] rs,
    input logic [DATA_W-1:0] rf
  );
    logic [DATA_W-1:0] v;
    if (!used || rs == '0)
      v = '0;
    else if (rs == ADDR_W'(NREG - 1))
      v = pc_rel;
    else if (wb_en && wb_addr == rs)
      v = wb_data;
    else
      v = rf;
    return v;
  endfunction

  assign flush_clr = flush && valid_q && slot_q.rd_we;

  reg_scoreboard #(
    .N (NREG),
    .AW(ADDR_W)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .set_en     (accept && dec.rd_we && dec.rd != '0),
    .set_addr   (dec.rd),
    .wb_clr_en  (wb_en),
    .wb_clr_addr(wb_addr),
    .cancel_en  (sb_cancel_en),
    .cancel_addr(sb_cancel_addr),
    .flush_en   (flush_clr),
    .flush_addr (slot_q.rd),
    .rd_a_addr  (dec.rs1),
    .rd_b_addr  (dec.rs2),
    .rd_a_busy  (busy1),
    .rd_b_busy  (busy2),
    .busy       (busy_eff)
  );

  assign hazard = (dec.rs1_use && dec.rs1 != '0 && busy1)
               || (dec.rs2_use && dec.rs2 != '0 && busy2)
               || (dec.rd_we && dec.rd != '0 && busy_eff[dec.rd]);

  assign in_ready = !reset && !flush && !hazard
                 && (!valid_q || out_ready);
  assign accept = in_valid && in_ready;

  always_comb begin
    slot_d = '0;
    slot_d.pc = in_pc;
    slot_d.op_a = fetch(dec.rs1_use, dec.rs1, rf_rd1_data);
    slot_d.op_b = fetch(dec.rs2_use, dec.rs2, rf_rd2_data);
    slot_d.imm = dec.imm;
    slot_d.rd = dec.rd;
    slot_d.rd_we = dec.rd_we;
    slot_d.alu_op = dec.alu_op;
    slot_d.use_imm = dec.use_imm;
    slot_d.is_load = dec.is_load;
    slot_d.is_store = dec.is_store;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      slot_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      slot_q <= slot_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_pc = slot_q.pc;
  assign out_op_a = slot_q.op_a;
  assign out_op_b = slot_q.op_b;
  assign out_imm = slot_q.imm;
  assign out_rd = slot_q.rd;
  assign out_rd_we = slot_q.rd_we;
  assign out_alu_op = slot_q.alu_op;
  assign out_use_imm = slot_q.use_imm;
  assign out_is_load = slot_q.is_load;
  assign out_is_store = slot_q.is_store;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: reference model plus
// directed scenarios with literal expectations.
module tb_operand_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [3:0] rf_rd1_addr;
  logic [3:0] rf_rd2_addr;
  logic [31:0] rf_rd1_data;
  logic [31:0] rf_rd2_data;
  logic wb_en;
  logic [3:0] wb_addr;
  logic [31:0] wb_data;
  logic sb_cancel_en;
  logic [3:0] sb_cancel_addr;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  logic [31:0] out_imm;
  logic [3:0] out_rd;
  logic out_rd_we;
  logic [3:0] out_alu_op;
  logic out_use_imm;
  logic out_is_load;
  logic out_is_store;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .rf_rd1_addr(rf_rd1_addr), .rf_rd2_addr(rf_rd2_addr),
    .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_cancel_en(sb_cancel_en),
    .sb_cancel_addr(sb_cancel_addr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op_a(out_op_a),
    .out_op_b(out_op_b), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_alu_op(out_alu_op), .out_use_imm(out_use_imm),
    .out_is_load(out_is_load), .out_is_store(out_is_store)
  );

  // register file stand-in: combinational read, write at edge
  logic [31:0] regs [16];
  assign rf_rd1_data = regs[rf_rd1_addr];
  assign rf_rd2_data = regs[rf_rd2_addr];
  always @(posedge clk)
    if (wb_en && wb_addr != 4'd0) regs[wb_addr] <= wb_data;

  task automatic cmp(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit u1; logic [3:0] r1;
    bit u2; logic [3:0] r2;
    bit we; logic [3:0] rd;
    logic [31:0] imm;
    bit ui; bit ld; bit st;
    logic [3:0] alu;
  } mdec_t;

  function automatic mdec_t mdec(logic [31:0] ir);
    mdec_t m;
    logic [1:0] cls;
    logic [3:0] op;
    cls = ir[27:26];
    op = ir[24:21];
    m = '{default: 0};
    m.r1 = ir[19:16];
    m.r2 = ir[3:0];
    m.rd = ir[15:12];
    m.alu = op;
    if (cls == 2'd0) begin
      m.u1 = !(op == 4'd13 || op == 4'd15);
      m.ui = ir[25];
      m.u2 = !ir[25];
      m.imm = ir[25] ? {24'd0, ir[7:0]} : 32'd0;
      m.we = !(op >= 4'd8 && op <= 4'd11);
    end else if (cls == 2'd1) begin
      m.u1 = 1;
      m.ui = 1;
      m.imm = {20'd0, ir[11:0]};
      m.ld = ir[20];
      m.st = !ir[20];
      m.we = ir[20];
      m.u2 = !ir[20];
      m.r2 = ir[15:12];
    end
    return m;
  endfunction

  logic [15:0] m_busy;
  bit m_valid;
  logic [31:0] m_pc, m_a, m_b, m_imm;
  logic [3:0] m_rd, m_alu;
  bit m_we, m_ui, m_ld, m_st;

  function automatic logic [15:0] m_cleared();
    logic [15:0] b;
    b = m_busy;
    if (wb_en) b[wb_addr] = 1'b0;
    if (sb_cancel_en) b[sb_cancel_addr] = 1'b0;
    if (flush && m_valid && m_we) b[m_rd] = 1'b0;
    return b;
  endfunction

  function automatic bit m_ready();
    mdec_t d;
    logic [15:0] b;
    bit hz;
    d = mdec(in_instr);
    b = m_cleared();
    hz = (d.u1 && d.r1 != 0 && b[d.r1])
      || (d.u2 && d.r2 != 0 && b[d.r2])
      || (d.we && d.rd != 0 && b[d.rd]);
    return !reset && !flush && !hz && (!m_valid || out_ready);
  endfunction

  function automatic logic [31:0] m_opnd(bit u, logic [3:0] r);
    if (!u || r == 0) return 32'd0;
    if (r == 15) return in_pc + 32'd8;
    if (wb_en && wb_addr == r) return wb_data;
    return regs[r];
  endfunction

  function automatic logic [15:0] m_setmask();
    mdec_t d;
    d = mdec(in_instr);
    if (in_valid && m_ready() && d.we && d.rd != 0)
      return 16'd1 << d.rd;
    return 16'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0; m_valid <= 0;
      m_pc <= 0; m_a <= 0; m_b <= 0; m_imm <= 0;
      m_rd <= 0; m_alu <= 0;
      m_we <= 0; m_ui <= 0; m_ld <= 0; m_st <= 0;
    end else begin
      m_busy <= m_cleared() | m_setmask();
      if (flush) begin
        m_valid <= 0;
      end else if (in_valid && m_ready()) begin
        m_valid <= 1;
        m_pc <= in_pc;
        m_a <= m_opnd(mdec(in_instr).u1, mdec(in_instr).r1);
        m_b <= m_opnd(mdec(in_instr).u2, mdec(in_instr).r2);
        m_imm <= mdec(in_instr).imm;
        m_rd <= mdec(in_instr).rd;
        m_we <= mdec(in_instr).we;
        m_alu <= mdec(in_instr).alu;
        m_ui <= mdec(in_instr).ui;
        m_ld <= mdec(in_instr).ld;
        m_st <= mdec(in_instr).st;
      end else if (out_ready) begin
        m_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_in_ready", in_ready, m_ready());
      cmp("m_out_valid", out_valid, m_valid);
      cmp("m_busy", dut.u_sb.busy_q, m_busy);
      if (m_valid) begin
        cmp("m_pc", out_pc, m_pc);
        cmp("m_op_a", out_op_a, m_a);
        cmp("m_op_b", out_op_b, m_b);
        cmp("m_imm", out_imm, m_imm);
        cmp("m_rd", out_rd, m_rd);
        cmp("m_rd_we", out_rd_we, m_we);
        cmp("m_alu_op", out_alu_op, m_alu);
        cmp("m_use_imm", out_use_imm, m_ui);
        cmp("m_is_load", out_is_load, m_ld);
        cmp("m_is_store", out_is_store, m_st);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [31:0] dp(logic [3:0] op, logic i,
    logic [3:0] rn, logic [3:0] rd, logic [7:0] op2);
    return {4'hE, 2'b00, i, op, 1'b0, rn, rd, 4'h0, op2};
  endfunction

  function automatic logic [31:0] ls(logic l, logic [3:0] rn,
    logic [3:0] rd, logic [11:0] imm);
    return {4'hE, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, l,
            rn, rd, imm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h100 + i;
    regs[0] = 0; regs[1] = 10; regs[2] = 20;
    reset = 1; in_valid = 0; in_instr = 0; in_pc = 32'h40;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    sb_cancel_en = 0; sb_cancel_addr = 0;
    flush = 0; out_ready = 1;
    cyc();
    chk_en = 1;
    cyc();
    cmp("rst_in_ready", in_ready, 0);
    cmp("rst_out_valid", out_valid, 0);
    cmp("rst_op_a", out_op_a, 0);
    cmp("rst_busy", dut.u_sb.busy_q, 0);

    // 1: ADD R3,R1,R2
    reset = 0; in_valid = 1; in_instr = dp(4'h4, 0, 1, 3, 2);
    #1 cmp("t1_ready", in_ready, 1);
    cyc();
    cmp("t1_valid", out_valid, 1);
    cmp("t1_op_a", out_op_a, 10);
    cmp("t1_op_b", out_op_b, 20);
    cmp("t1_rd", out_rd, 3);
    cmp("t1_busy3", dut.u_sb.busy_q[3], 1);

    // 2: ADD R4,R3,R3 stalls, then bypass on wb R3
    in_instr = dp(4'h4, 0, 3, 4, 3);
    #1 cmp("t2_stall", in_ready, 0);
    cyc();
    cmp("t2_drain", out_valid, 0);
    wb_en = 1; wb_addr = 3; wb_data = 32'h1E;
    #1 cmp("t2_ready", in_ready, 1);
    cyc();
    wb_en = 0;
    cmp("t2_op_a", out_op_a, 32'h1E);
    cmp("t2_op_b", out_op_b, 32'h1E);
    cmp("t2_rd", out_rd, 4);
    cmp("t2_busy", dut.u_sb.busy_q, 16'h0010);

    // 3: hold slot for 3 cycles
    in_instr = dp(4'h4, 0, 1, 7, 2);
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1 cmp("t3_ready", in_ready, 0);
      cyc();
      cmp("t3_valid", out_valid, 1);
      cmp("t3_rd", out_rd, 4);
      cmp("t3_op_a", out_op_a, 32'h1E);
      cmp("t3_busy", dut.u_sb.busy_q, 16'h0010);
    end
    out_ready = 1;
    cyc();
    cmp("t3_next_rd", out_rd, 7);
    cmp("t3_next_busy", dut.u_sb.busy_q, 16'h0090);

    // 4: MOV R5,#0xFF then flush while held
    in_instr = dp(4'hD, 1, 0, 5, 8'hFF);
    cyc();
    cmp("t4_imm", out_imm, 32'hFF);
    cmp("t4_use_imm", out_use_imm, 1);
    cmp("t4_op_a", out_op_a, 0);
    cmp("t4_busy", dut.u_sb.busy_q, 16'h00B0);
    out_ready = 0; flush = 1; in_instr = dp(4'h4, 0, 1, 8, 2);
    #1 cmp("t4_flush_ready", in_ready, 0);
    cyc();
    flush = 0; in_valid = 0;
    cmp("t4_valid", out_valid, 0);
    cmp("t4_busy_after", dut.u_sb.busy_q, 16'h0090);
    sb_cancel_en = 1; sb_cancel_addr = 7;
    wb_en = 1; wb_addr = 4; wb_data = 32'h44;
    cyc();
    sb_cancel_en = 0; wb_en = 0;
    cmp("t4_busy_clr", dut.u_sb.busy_q, 0);

    // 5: R0 after wb to R0, R15 reads pc+8
    out_ready = 1; in_valid = 1; in_pc = 32'h100;
    in_instr = dp(4'h4, 0, 0, 9, 8'h0F);
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    cyc();
    wb_en = 0;
    cmp("t5_r0", out_op_a, 0);
    cmp("t5_r15", out_op_b, 32'h108);
    cmp("t5_pc", out_pc, 32'h100);
    in_instr = dp(4'hA, 0, 1, 0, 2);
    cyc();
    cmp("t5_cmp_we", out_rd_we, 0);
    in_instr = 32'hEA00_1234;
    cyc();
    cmp("t5_nop_we", out_rd_we, 0);
    cmp("t5_nop_a", out_op_a, 0);

    // 6: LDR R6,[R1,#4] then STR R6,[R2]
    in_pc = 32'h200;
    in_instr = ls(1, 1, 6, 12'd4);
    cyc();
    cmp("t6_ld", out_is_load, 1);
    cmp("t6_ld_a", out_op_a, 10);
    cmp("t6_ld_imm", out_imm, 4);
    cmp("t6_ld_rd", out_rd, 6);
    in_instr = ls(0, 2, 6, 12'd0);
    #1 cmp("t6_stall1", in_ready, 0);
    cyc();
    #1 cmp("t6_stall2", in_ready, 0);
    wb_en = 1; wb_addr = 6; wb_data = 32'hABCD;
    #1 cmp("t6_ready", in_ready, 1);
    cyc();
    wb_en = 0;
    cmp("t6_st", out_is_store, 1);
    cmp("t6_st_a", out_op_a, 20);
    cmp("t6_st_b", out_op_b, 32'hABCD);
    cmp("t6_st_imm", out_imm, 0);
    cmp("t6_st_we", out_rd_we, 0);

    // reset mid-operation
    in_instr = dp(4'h4, 0, 1, 10, 2);
    cyc();
    reset = 1;
    cyc();
    cmp("mr_valid", out_valid, 0);
    cmp("mr_busy", dut.u_sb.busy_q, 0);
    cmp("mr_op_a", out_op_a, 0);
    reset = 0; in_valid = 0;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
